// File: rtl/fp13_pkg.sv
// Shared definitions for the 13-bit {sign, exp[3:0], frac[7:0]} float used on the compare path.
// The converter and the greater-than comparator both import fp13_t from here.
package fp13_pkg;

  localparam int FP13_EXP_W  = 4;
  localparam int FP13_FRAC_W = 8;
  localparam int FP13_W      = 13;
  localparam logic [FP13_W-1:0] FP13_MAX = 13'h0FFF;

  localparam int FP13_INT_W = 16;
  localparam logic [4:0] FP13_EXP_INIT = 5'd16;

  typedef struct packed {
    logic                   sign;
    logic [FP13_EXP_W-1:0]  exp;
    logic [FP13_FRAC_W-1:0] frac;
  } fp13_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp13_pack.sv
// Combinational packer: normalized magnitude + exponent count -> fp13_t, with saturation.
// Zero latency, no handshake; FP_ROUND_EN selects round half-up instead of truncation.
module fp13_pack
  import fp13_pkg::*;
(
  input  logic        sign,
  input  logic [15:0] mag,
  input  logic [4:0]  exp_cnt,
  output fp13_t       result
);

  logic [FP13_FRAC_W-1:0] frac;
  logic [4:0]             exp_adj;

`ifdef FP_ROUND_EN
  logic [FP13_FRAC_W:0] frac_rnd;

  always_comb begin
    frac_rnd = {1'b0, mag[15:8]} + {8'd0, mag[7]};
    frac     = frac_rnd[FP13_FRAC_W-1:0];
    exp_adj  = exp_cnt;
    // Carry out of the fraction renormalizes to 0.1000_0000 one binade up.
    if (frac_rnd[FP13_FRAC_W]) begin
      frac    = 8'h80;
      exp_adj = exp_cnt + 5'd1;
    end
  end
`else
  always_comb begin
    frac    = mag[15:8];
    exp_adj = exp_cnt;
  end
`endif

  always_comb begin
    result = '0;
    if (mag == '0) begin
      result = '0;
    end else if (exp_adj >= FP13_EXP_INIT) begin
      result = {sign, FP13_MAX[FP13_W-2:0]};
    end else begin
      result.sign = sign;
      result.exp  = exp_adj[FP13_EXP_W-1:0];
      result.frac = frac;
    end
  end

endmodule

// File: rtl/int_to_floating_point.sv
// int16 -> fp13 converter, normalizing one bit per cycle; result k+1 clocks after capture (k = leading zeros).
// Result held in DONE until out_ready; in_ready only in IDLE or when DONE is consumed. FP_ROUND_EN enables rounding.
module int_to_floating_point
  import fp13_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [12:0] out_data,
  input  logic        out_ready,
  output logic        out_valid
);

  state_t      state, state_nxt;
  logic        sign_q;
  logic [15:0] mag_q;
  logic [4:0]  exp_cnt_q;
  fp13_t       out_q;
  fp13_t       packed_fp;

  logic        capture;
  logic        norm_done;
  logic [15:0] in_mag;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign capture   = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_data  = out_q;

  // -32768 wraps back to 0x8000, which is exactly its unsigned magnitude.
  assign in_mag    = in_data[15] ? (~in_data + 16'd1) : in_data;
  assign norm_done = (mag_q == '0) || mag_q[15];

  fp13_pack u_pack (
    .sign    (sign_q),
    .mag     (mag_q),
    .exp_cnt (exp_cnt_q),
    .result  (packed_fp)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (capture) state_nxt = NORM;
      NORM: if (norm_done) state_nxt = DONE;
      DONE: begin
        if (capture)        state_nxt = NORM;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_cnt_q <= '0;
      out_q     <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        sign_q    <= in_data[15];
        mag_q     <= in_mag;
        exp_cnt_q <= FP13_EXP_INIT;
      end else if (state == NORM) begin
        if (norm_done) begin
          out_q <= packed_fp;
        end else begin
          mag_q     <= {mag_q[14:0], 1'b0};
          exp_cnt_q <= exp_cnt_q - 5'd1;
        end
      end
    end
  end

endmodule
